// File: rtl/tdc_decoder.sv
// -----------------------------------------------------------------------------
// tdc_decoder
//
// Front-end for the DPLL delay-line TDC. It registers the raw thermometer
// sample on each reference edge. It can clean single-tap bubbles with a 3-tap
// majority vote. It then finds the first two rising transitions, which gives:
//   - a phase code (index of the first rising tap),
//   - a DCO period estimate in taps (distance from first to second rise),
//   - a block average of the phase for the loop filter.
//
// Ports
//   ref_clk            reference clock, all state on its rising edge
//   csr_tdc_rst_n      asynchronous active-low reset
//   csr_tdc_en         decoder enable; when low the pipeline drains silently
//   csr_tdc_bubble_en  enable majority bubble correction (read at stage 2)
//   sampled_tdc        raw tap samples, bit i = DCO level at tap i
//   phase_out          index of first rising transition (holds if none)
//   period_out         tap distance first->second rise (holds if none)
//   out_valid          one-cycle pulse per decoded sample
//   edge_found         phase_out is fresh for this out_valid
//   period_valid       period_out is fresh for this out_valid
//   avg_out            block-averaged phase
//   avg_valid          one-cycle pulse when avg_out updates
//   err_cnt            saturating count of decoded samples with no rising edge
//
// Handshake: there is no backpressure. Each *_valid output is a single-cycle
// qualifier for the data outputs that belong to it, and it is sampled on the
// next ref_clk rising edge.
// -----------------------------------------------------------------------------
module tdc_decoder #(
    parameter int TDC_W    = 64,
    parameter int PW       = $clog2(TDC_W),
    parameter int AVG_LOG2 = 2
) (
    input  logic             ref_clk,
    input  logic             csr_tdc_rst_n,
    input  logic             csr_tdc_en,
    input  logic             csr_tdc_bubble_en,
    input  logic [TDC_W-1:0] sampled_tdc,
    output logic [PW-1:0]    phase_out,
    output logic [PW-1:0]    period_out,
    output logic             out_valid,
    output logic             edge_found,
    output logic             period_valid,
    output logic [PW-1:0]    avg_out,
    output logic             avg_valid,
    output logic [15:0]      err_cnt
);

    localparam int            AW      = PW + AVG_LOG2;
    localparam int            CW      = AVG_LOG2 + 1;
    localparam logic [CW-1:0] BLK_LEN = CW'(1 << AVG_LOG2);

    // Stage 1
    logic [TDC_W-1:0] s1_q, s1_d;
    logic             v1_q, v1_d;
    // Stage 2
    logic             v2_q, v2_d;
    logic [PW-1:0]    r1_q, r1_d, r2_q, r2_d;
    logic             r1_found_q, r1_found_d, r2_found_q, r2_found_d;
    // Stage 3 outputs
    logic [PW-1:0]    phase_q, phase_d, period_q, period_d;
    logic             out_valid_q, out_valid_d;
    logic             edge_found_q, edge_found_d;
    logic             period_valid_q, period_valid_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    // Averager
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PW-1:0]    avg_q, avg_d;
    logic             avg_valid_q, avg_valid_d;

    // Stage-2 combinational decode
    logic [TDC_W-1:0] c, rise, rise_lo, rise_rest;
    logic [AW-1:0]    sum;
    logic [CW-1:0]    cnt_inc;

    always_comb begin
        c = s1_q;
        if (csr_tdc_bubble_en) begin
            for (int i = 1; i < TDC_W - 1; i++) begin
                c[i] = (s1_q[i-1] & s1_q[i]) | (s1_q[i] & s1_q[i+1]) |
                       (s1_q[i-1] & s1_q[i+1]);
            end
        end
        // Shifting in a 1 below tap 0 means tap 0 can never count as a rise.
        rise      = c & ~{c[TDC_W-2:0], 1'b1};
        // Isolate the lowest rise; the remaining rises feed the second encoder.
        // Both encoders then run in parallel instead of one after the other.
        rise_lo   = rise & (~rise + TDC_W'(1));
        rise_rest = rise & ~rise_lo;

        r1_d       = '0;
        r2_d       = '0;
        r1_found_d = |rise;
        r2_found_d = |rise_rest;
        for (int i = TDC_W - 1; i >= 1; i--) begin
            if (rise[i])      r1_d = PW'(i);
            if (rise_rest[i]) r2_d = PW'(i);
        end
    end

    always_comb begin
        s1_d = csr_tdc_en ? sampled_tdc : s1_q;
        v1_d = csr_tdc_en;
        v2_d = v1_q & csr_tdc_en;

        out_valid_d    = v2_q & csr_tdc_en;
        edge_found_d   = out_valid_d & r1_found_q;
        period_valid_d = out_valid_d & r1_found_q & r2_found_q;
        phase_d        = edge_found_d ? r1_q : phase_q;
        period_d       = period_valid_d ? (r2_q - r1_q) : period_q;
        err_cnt_d      = err_cnt_q;
        if (out_valid_d && !r1_found_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        // The averager consumes the stage-3 registers, so it runs one cycle
        // behind out_valid.
        sum         = acc_q + AW'(phase_q);
        cnt_inc     = cnt_q + CW'(1);
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (!csr_tdc_en) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (out_valid_q && edge_found_q) begin
            if (cnt_inc == BLK_LEN) begin
                avg_d       = PW'(sum >> AVG_LOG2);
                avg_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge ref_clk or negedge csr_tdc_rst_n) begin
        if (!csr_tdc_rst_n) begin
            s1_q           <= '0;
            v1_q           <= 1'b0;
            v2_q           <= 1'b0;
            r1_q           <= '0;
            r2_q           <= '0;
            r1_found_q     <= 1'b0;
            r2_found_q     <= 1'b0;
            phase_q        <= '0;
            period_q       <= '0;
            out_valid_q    <= 1'b0;
            edge_found_q   <= 1'b0;
            period_valid_q <= 1'b0;
            err_cnt_q      <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            avg_q          <= '0;
            avg_valid_q    <= 1'b0;
        end else begin
            s1_q           <= s1_d;
            v1_q           <= v1_d;
            v2_q           <= v2_d;
            r1_q           <= r1_d;
            r2_q           <= r2_d;
            r1_found_q     <= r1_found_d;
            r2_found_q     <= r2_found_d;
            phase_q        <= phase_d;
            period_q       <= period_d;
            out_valid_q    <= out_valid_d;
            edge_found_q   <= edge_found_d;
            period_valid_q <= period_valid_d;
            err_cnt_q      <= err_cnt_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            avg_q          <= avg_d;
            avg_valid_q    <= avg_valid_d;
        end
    end

    assign phase_out    = phase_q;
    assign period_out   = period_q;
    assign out_valid    = out_valid_q;
    assign edge_found   = edge_found_q;
    assign period_valid = period_valid_q;
    assign avg_out      = avg_q;
    assign avg_valid    = avg_valid_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: doc/tdc_decoder.md
# tdc_decoder

Parametrised digital front-end for the DPLL's delay-line TDC. Captures the raw `sampled_tdc` thermometer word on every reference edge and applies optional bubble correction. It then locates the first and second rising transitions of the sampled DCO waveform and reports a binary phase code, a DCO period estimate in taps, and a block-averaged phase for the loop filter. It sits between the analog TDC output and the DLF input, and generalises the fixed 64-tap interface to any tap count with selectable averaging depth.

## Interface
- `TDC_W`, 64, number of delay-line taps (≥8).
- `PW`, `$clog2(TDC_W)`, width of phase/period codes (derived).
- `AVG_LOG2`, 2, log2 of averaging block length (0..6); 0 means every sample is its own block.
- `ref_clk` input 1 — reference clock; all logic on its rising edge.
- `csr_tdc_rst_n` input 1 — asynchronous active-low reset.
- `csr_tdc_en` input 1 — decoder enable.
- `csr_tdc_bubble_en` input 1 — enable 3-tap majority bubble correction.
- `sampled_tdc` input TDC_W — raw tap samples; bit i is DCO level at tap i.
- `phase_out` output PW — index of first rising transition.
- `period_out` output PW — tap distance between first and second rising transitions.
- `out_valid` output 1 — one-cycle pulse per decoded sample.
- `edge_found` output 1 — qualifies `phase_out` for the current `out_valid`.
- `period_valid` output 1 — qualifies `period_out` for the current `out_valid`.
- `avg_out` output PW — block-averaged phase.
- `avg_valid` output 1 — one-cycle pulse when `avg_out` updates.
- `err_cnt` output 16 — saturating count of samples with no rising edge.

## Operation
- Stage 1 (S1): register `sampled_tdc` into `s1` when `csr_tdc_en`=1. The valid bit v1 follows `csr_tdc_en`.
- Stage 2 (S2), bubble fix:
  - For 1≤i≤TDC_W-2, `c[i]=maj(s1[i-1],s1[i],s1[i+1])`.
  - `c[0]=s1[0]`, `c[TDC_W-1]=s1[TDC_W-1]`.
  - When `csr_tdc_bubble_en`=0, `c=s1`.
  - The bubble-enable bit is sampled combinationally at S2.
- Rising transition at i (1≤i≤TDC_W-1) when `c[i]=1` and `c[i-1]=0`. Tap 0 can never be an edge.
- S2 priority-encodes the lowest rising index r1 and the next rising index r2>r1, and registers the results with v2.
- S3 output register, when v2=1:
  - `out_valid`=1.
  - `edge_found`=(r1 exists). If it exists, `phase_out`=r1; otherwise `phase_out` holds its previous value.
  - `period_valid`=(r1 and r2 exist). If valid, `period_out`=r2−r1 (unsigned, fits PW); otherwise `period_out` holds.
  - If no edge, `err_cnt`+=1, saturating at 16'hFFFF.
- Averager:
  - State: accumulator `acc` of width PW+AVG_LOG2, and sample counter `cnt` of width AVG_LOG2+1.
  - Only samples with `edge_found`=1 are accumulated.
  - When the accumulated sample makes `cnt` reach 2^AVG_LOG2: `avg_out`=(acc+phase)>>AVG_LOG2 (truncate), `avg_valid`=1, and `acc` and `cnt` clear to 0 in the same cycle.
  - No-edge samples neither add nor count.
- `csr_tdc_en`=0:
  - v1, v2 and all valid pulses go to 0 from the next edge, so the pipeline drains without emitting.
  - `acc` and `cnt` clear to 0.
  - `phase_out`, `period_out`, `avg_out` and `err_cnt` hold.
  - Re-enabling starts a fresh averaging block.
- Reset (asynchronous, any cycle, including mid-block):
  - `s1`, pipeline valids, `acc`, `cnt` → 0.
  - `phase_out`, `period_out`, `avg_out` → 0.
  - `out_valid`, `edge_found`, `period_valid`, `avg_valid` → 0.
  - `err_cnt` → 0.
- Release is synchronous to the next `ref_clk` rising edge. The first capture occurs on the first edge with the reset deasserted and `csr_tdc_en`=1.

## Timing
- Sample captured at edge n appears on `phase_out`/`out_valid` after edge n+2 (latency 2 cycles, throughput 1 sample/cycle).
- `avg_valid` asserts after edge n+3, where n is the capture edge of the block's last qualifying sample.
- `out_valid` and `avg_valid` are single-cycle pulses, never stretched.
- With `csr_tdc_en` continuously 1, `out_valid`=1 every cycle.
- `err_cnt` updates in the same cycle as the corresponding `out_valid`.
- Critical path: S2 majority plus two priority encoders over TDC_W bits. It must close at the reference clock for TDC_W=128.

## Test plan
- Reset: assert `csr_tdc_rst_n`=0 mid-stream → all outputs 0 immediately. After release with `csr_tdc_en`=1 → the first `out_valid` appears 2 cycles after the first capture edge.
- Decode: TDC_W=64, `sampled_tdc`=64'h00FF_00FF_00FF_0000 → `phase_out`=16, `period_out`=16, `edge_found`=1, `period_valid`=1.
- Bubble: `sampled_tdc`=64'h0000_0000_0000_FB00.
  - With `csr_tdc_bubble_en`=1 → `phase_out`=8, `period_valid`=0.
  - With `csr_tdc_bubble_en`=0 → `phase_out`=8, `period_out`=3, `period_valid`=1.
- No edge: drive 64'h0 for 3 cycles, then 64'hFFFF_FFFF_FFFF_FFFF for 2 cycles.
  - `edge_found`=0 on all 5 pulses; `err_cnt`=5.
  - `phase_out` holds its prior value.
  - No `avg_valid`.
- Averaging: AVG_LOG2=2, phases 16, 17, 0-edge, 18, 20 → one `avg_valid` with `avg_out`=17 (71>>2), 1 cycle after the 20 sample's `out_valid`.
- Enable gating: drop `csr_tdc_en` after 2 samples of a 4-sample block, then re-enable → no pulses while disabled, and the next `avg_valid` requires 4 new qualifying samples.
